dbi_ac_encoder: RTL and testbench
=================================

Name: dbi_ac_encoder

Overview:
- Byte-lane DBI-AC encoder with a valid/ready handshake.
- Tracks the last driven 9-line bus state (DQ[7:0] plus DBI) and forms the 9-bit transition vector for each incoming byte.
- Uses a 9-input majority decision to invert the byte when 5 or more lines would toggle, then registers the encoded DQ/DBI toward the PHY.
- Sits between the write-data FIFO and the lane serializer, so at most 4 of the 9 lines toggle per beat.

Parameters:
- IDLE_DQ, 8'hFF, DQ bus level at reset and after a burst ends (POD idle-high).
- IDLE_DBI, 1'b1, DBI line level at reset and after a burst ends.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  single clock, all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- dbi_en  in  1  1 = encoding enabled; 0 = pass-through (out_dbi=0, no inversion).
- stat_clr  in  1  synchronous clear of stat_words and stat_inv.
- in_valid  in  1  input byte valid.
- in_ready  out  1  encoder can accept a byte.
- in_data  in  8  raw data byte.
- in_last  in  1  byte is the final beat of a burst.
- out_valid  out  1  encoded beat valid.
- out_ready  in  1  serializer accepts the beat.
- out_dq  out  8  encoded data lines.
- out_dbi  out  1  DBI line (1 = byte inverted).
- out_last  out  1  registered copy of in_last.
- stat_words  out  CNT_W  accepted beats, saturating.
- stat_inv  out  CNT_W  inverted beats, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_dq=IDLE_DQ, out_dbi=IDLE_DBI, out_last=0, hist_dq=IDLE_DQ, hist_dbi=IDLE_DBI, both stat counters 0.
- Handshake and latency:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept happens when in_valid && in_ready.
  - Latency is 1 cycle: an accepted byte appears on out_* the next cycle with out_valid=1.
  - out_* hold stable while out_valid && !out_ready.
  - If there is no accept and out_ready=1, out_valid goes to 0; out_dq/out_dbi keep their last value.
  - Back-to-back full throughput at 1 beat/cycle when out_ready is held high.
- Decision, combinational on in_data vs history:
  - t[7:0] = in_data ^ hist_dq; t[8] = hist_dbi (the DBI toggle if sent as 0).
  - inv = dbi_en && (popcount(t) >= 5).
  - Encoded dq = inv ? ~in_data : in_data; encoded dbi = inv.
  - Result: total toggles ≤ 4 whenever dbi_en=1.
- History update on accept:
  - in_last=0: hist takes the encoded {dq,dbi}.
  - in_last=1: hist returns to {IDLE_DQ, IDLE_DBI}, since the bus parks at idle between bursts.
  - The output register itself still presents the last beat.
- dbi_en=0: out_dbi=0 and out_dq=in_data. History still updates, so a mid-stream re-enable uses the true bus state.
- Statistics:
  - stat_words increments on each accept; stat_inv increments on accept with inv=1.
  - Both saturate at all-ones and never wrap.
  - stat_clr zeroes both and has priority over the same-cycle increment.
- Reset mid-burst: all state returns to reset values immediately; the partial burst is discarded and no out_valid is produced.
- No internal FSM beyond the output-register full/empty bit; bursts are delimited only by in_last.

Decomposition:
- Shared package dbi_pkg holds DQ_W=8, LINES=9, MAJ_THRESH=5, and the idle-level defaults.
- One sub-module, dbi_maj9: purely combinational 9-in majority (popcount ≥ 5). It is instantiated once on t[8:0] and gated by dbi_en in the parent.

Test Plan:
- Reset value: assert rst async mid-cycle -> out_valid=0, out_dq=8'hFF, out_dbi=1 immediately, without waiting for a clock edge.
- Inversion at the idle edge: from idle, send 8'h00 (last=0) -> out_dq=8'hFF, out_dbi=1 (9 toggles → invert); then 8'h0F -> out_dq=8'hF0, out_dbi=1 (4 data + 1 DBI = 5 → invert, result 4 toggles).
- Threshold just below: history 8'h00/dbi=0, send 8'h0F -> 4 toggles, no invert, out_dq=8'h0F, out_dbi=0, stat_inv unchanged.
- Burst end: send 8'h00 with in_last=1, then 8'h00 -> second beat is compared against idle 8'hFF/1 again, so out_dq=8'hFF, out_dbi=1 and out_last goes 1 then 0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_* frozen; release -> stream resumes with no loss or duplication, and stat_words counts exactly the accepted beats.
- Statistics saturation: preload by streaming 2^16+2 inverting beats -> stat_inv=16'hFFFF stays there; stat_clr pulse with a same-cycle accept -> both counters read 0.

Source files
------------

// File: rtl/dbi_pkg.sv
// Shared constants and types for the DBI-AC byte-lane encoder.
// Lane geometry, the majority threshold and the POD idle bus levels.
package dbi_pkg;

    localparam int DQ_W       = 8;
    localparam int LINES      = 9;
    localparam int MAJ_THRESH = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [DQ_W-1:0] IDLE_DQ_DEF  = 8'hFF;
    localparam logic            IDLE_DBI_DEF = 1'b1;

    // One beat as seen on the wires: data lines plus the DBI line.
    typedef struct packed {
        logic [DQ_W-1:0] dq;
        logic            dbi;
    } beat_t;

endpackage

// File: rtl/dbi_ac_encoder_if.sv
// Byte-lane stream between the write-data FIFO side and the lane serializer.
// The master drives raw bytes in and consumes encoded beats; the encoder is the slave.
interface dbi_ac_encoder_if;
    import dbi_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [DQ_W-1:0] in_data;
    logic            in_last;

    logic            out_valid;
    logic            out_ready;
    logic [DQ_W-1:0] out_dq;
    logic            out_dbi;
    logic            out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_dq, out_dbi, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_dq, out_dbi, out_last
    );

endinterface

// File: rtl/dbi_maj9.sv
// Combinational 9-input majority: asserts when MAJ_THRESH or more lines are set.
module dbi_maj9
    import dbi_pkg::*;
(
    input  logic [LINES-1:0] t,
    output logic             maj
);

    logic [3:0] cnt;

    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < LINES; i++) begin
            cnt = cnt + {3'd0, t[i]};
        end
        maj = (cnt >= 4'(MAJ_THRESH));
    end

endmodule

// File: rtl/dbi_ac_encoder.sv
// DBI-AC encoder: inverts a byte when 5+ of the 9 lines would toggle against the
// last driven bus state, then registers the encoded beat toward the PHY.
module dbi_ac_encoder
    import dbi_pkg::*;
#(
    parameter logic [DQ_W-1:0] IDLE_DQ  = IDLE_DQ_DEF,
    parameter logic            IDLE_DBI = IDLE_DBI_DEF,
    parameter int              CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbi_en,
    input  logic              stat_clr,
    dbi_ac_encoder_if.slave   bus,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_inv
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam beat_t            IDLE_BEAT = '{dq: IDLE_DQ, dbi: IDLE_DBI};

    logic             out_valid_q, out_valid_d;
    beat_t            out_beat_q,  out_beat_d;
    logic             out_last_q,  out_last_d;
    beat_t            hist_q,      hist_d;
    logic [CNT_W-1:0] stat_words_q, stat_words_d;
    logic [CNT_W-1:0] stat_inv_q,   stat_inv_d;

    logic             in_ready;
    logic             accept;
    logic [LINES-1:0] toggles;
    logic             maj;
    logic             inv;
    beat_t            enc;

    // t[8] is the DBI toggle that would occur if the byte went out non-inverted.
    assign toggles = {hist_q.dbi, bus.in_data ^ hist_q.dq};

    dbi_maj9 u_maj9 (
        .t   (toggles),
        .maj (maj)
    );

    always_comb begin
        in_ready = !out_valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready;
        inv      = dbi_en && maj;
        enc.dq   = inv ? ~bus.in_data : bus.in_data;
        enc.dbi  = inv;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        out_last_d   = out_last_q;
        hist_d       = hist_q;
        stat_words_d = stat_words_q;
        stat_inv_d   = stat_inv_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_beat_d  = enc;
            out_last_d  = bus.in_last;
            // The bus parks at idle between bursts, so the next burst starts from there.
            hist_d      = bus.in_last ? IDLE_BEAT : enc;
            if (stat_words_q != '1) begin
                stat_words_d = stat_words_q + CNT_ONE;
            end
            if (inv && (stat_inv_q != '1)) begin
                stat_inv_d = stat_inv_q + CNT_ONE;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (stat_clr) begin
            stat_words_d = '0;
            stat_inv_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= IDLE_BEAT;
            out_last_q   <= 1'b0;
            hist_q       <= IDLE_BEAT;
            stat_words_q <= '0;
            stat_inv_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            out_last_q   <= out_last_d;
            hist_q       <= hist_d;
            stat_words_q <= stat_words_d;
            stat_inv_q   <= stat_inv_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dq    = out_beat_q.dq;
    assign bus.out_dbi   = out_beat_q.dbi;
    assign bus.out_last  = out_last_q;
    assign stat_words    = stat_words_q;
    assign stat_inv      = stat_inv_q;

endmodule

// File: tb/tb_dbi_ac_encoder.sv
// Scoreboard bench for dbi_ac_encoder: directed bytes with hand-computed encodings
// are queued at accept time and compared by a monitor when beats leave the encoder.
module tb_dbi_ac_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbi_en;
    logic        stat_clr;
    logic [15:0] stat_words;
    logic [15:0] stat_inv;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_words = 16'd0;
    logic [15:0] exp_inv   = 16'd0;

    typedef struct packed {
        logic [7:0] dq;
        logic       dbi;
        logic       last;
    } exp_t;

    exp_t sb[$];

    dbi_ac_encoder_if bus ();

    dbi_ac_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .dbi_en     (dbi_en),
        .stat_clr   (stat_clr),
        .bus        (bus),
        .stat_words (stat_words),
        .stat_inv   (stat_inv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one byte and hold it until accepted; queue its expected encoding.
    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] edq, input logic edbi);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{dq: edq, dbi: edbi, last: l});
                if (exp_words != 16'hFFFF) exp_words++;
                if (edbi && exp_inv != 16'hFFFF) exp_inv++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 20) begin
                chk("accept_timeout", 32'(n), 32'd0);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every beat the serializer takes is compared against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'({bus.out_dq, bus.out_dbi, bus.out_last}), 32'h3FF);
                end else begin
                    chk("beat", 32'({bus.out_dq, bus.out_dbi, bus.out_last}), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        dbi_en        = 1'b1;
        stat_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_dq",    32'(bus.out_dq),    32'hFF);
        chk("rst_out_dbi",   32'(bus.out_dbi),   32'd1);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_words",     32'(stat_words),    32'd0);
        rst = 1'b0;
        idle(1);

        // From idle FF/1: 00 toggles all 9 lines, 0F toggles 4 data + DBI.
        send(8'h00, 1'b0, 8'hFF, 1'b1);
        send(8'h0F, 1'b0, 8'hF0, 1'b1);
        idle(1);
        chk("stat_inv_pair", 32'(stat_inv), 32'(exp_inv));

        // Park a beat under backpressure, then reset asynchronously mid-cycle.
        bus.out_ready = 1'b0;
        send(8'h3C, 1'b0, 8'hC3, 1'b1);
        #2;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_dq",    32'(bus.out_dq),    32'hFF);
        chk("async_rst_dbi",   32'(bus.out_dbi),   32'd1);
        chk("async_rst_words", 32'(stat_words),    32'd0);
        sb.delete();
        exp_words     = 16'd0;
        exp_inv       = 16'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_no_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        idle(1);

        // Pass-through leaves 00/0 on the bus; 0F then toggles only 4 lines.
        dbi_en = 1'b0;
        send(8'h00, 1'b0, 8'h00, 1'b0);
        dbi_en = 1'b1;
        send(8'h0F, 1'b0, 8'h0F, 1'b0);
        idle(1);
        chk("thresh_stat_inv", 32'(stat_inv), 32'd0);
        send(8'hF0, 1'b0, 8'h0F, 1'b1);

        // Burst end returns history to idle for the next byte.
        send(8'h00, 1'b1, 8'hFF, 1'b1);
        send(8'h00, 1'b0, 8'hFF, 1'b1);
        idle(2);

        // Backpressure: hold the serializer off for 3 cycles.
        bus.out_ready = 1'b0;
        send(8'h3C, 1'b0, 8'hC3, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_dq",    32'(bus.out_dq),    32'hC3);
            chk("bp_out_dbi",   32'(bus.out_dbi),   32'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(8'hC3, 1'b0, 8'hC3, 1'b0);
        send(8'h3C, 1'b0, 8'hC3, 1'b1);
        send(8'h81, 1'b1, 8'h81, 1'b0);
        idle(2);
        chk("bp_stat_words", 32'(stat_words), 32'(exp_words));
        chk("bp_stat_inv",   32'(stat_inv),   32'(exp_inv));
        chk("bp_words_abs",  32'(stat_words), 32'd9);

        // Saturation: every idle-anchored 00 byte inverts.
        for (int i = 0; i < 65538; i++) begin
            send(8'h00, 1'b1, 8'hFF, 1'b1);
        end
        idle(1);
        chk("sat_inv",   32'(stat_inv),   32'hFFFF);
        chk("sat_words", 32'(stat_words), 32'hFFFF);

        stat_clr = 1'b1;
        send(8'h00, 1'b1, 8'hFF, 1'b1);
        stat_clr  = 1'b0;
        exp_words = 16'd0;
        exp_inv   = 16'd0;
        chk("clr_words", 32'(stat_words), 32'd0);
        chk("clr_inv",   32'(stat_inv),   32'd0);

        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
